// File: rtl/stft_frame_reader.sv
// Read side of the STFT sample buffer: counts committed samples, then streams one
// overlapping FRAME_LEN-sample frame from the circular RAM and advances by HOP.
module stft_frame_reader #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FRAME_LEN     = 16,
  parameter int HOP           = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_strobe,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [WORD_WIDTH-1:0]    rd_data,
  output logic [WORD_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     overrun
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;

  localparam logic [CW-1:0]            FRAME_LEN_C = CW'(FRAME_LEN);
  localparam logic [CW-1:0]            DEPTH_C     = CW'(DEPTH);
  localparam logic [CW:0]              DEPTH_X     = (CW + 1)'(DEPTH);
  localparam logic [CW:0]              HOP_X       = (CW + 1)'(HOP);
  localparam logic [ADDRESS_WIDTH-1:0] HOP_A       = ADDRESS_WIDTH'(HOP);
  localparam logic [CW-1:0]            ONE_C       = CW'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            avail_q, avail_d;
  logic [WORD_WIDTH-1:0]    m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     retire_s;
  logic [CW:0]              avail_sum_s;

  always_comb begin
    if (state_q == STREAM) begin
      rd_addr = base_q + idx_q[ADDRESS_WIDTH-1:0];
    end else begin
      rd_addr = base_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    retire_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (avail_q >= FRAME_LEN_C) begin
          m_data_d  = rd_data;
          m_valid_d = 1'b1;
          idx_d     = ONE_C;
          state_d   = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (m_valid_q && m_ready) begin
          if (idx_q == FRAME_LEN_C) begin
            m_valid_d = 1'b0;
            base_d    = base_q + HOP_A;
            idx_d     = '0;
            retire_s  = 1'b1;
            state_d   = IDLE;
          end else begin
            m_data_d = rd_data;
            idx_d    = idx_q + ONE_C;
          end
        end else begin
          state_d = STREAM;
        end
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
        idx_d     = '0;
      end
    endcase

    // Retire never underflows: a frame only starts once avail >= FRAME_LEN >= HOP.
    avail_sum_s = {1'b0, avail_q} + {{CW{1'b0}}, wr_strobe};
    if (retire_s) begin
      avail_sum_s = avail_sum_s - HOP_X;
    end else begin
      avail_sum_s = avail_sum_s;
    end

    if (avail_sum_s > DEPTH_X) begin
      avail_d   = DEPTH_C;
      overrun_d = 1'b1;
    end else begin
      avail_d   = avail_sum_s[CW-1:0];
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      idx_q     <= '0;
      avail_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      avail_q   <= avail_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;
  assign m_last  = m_valid_q & (state_q == STREAM) & (idx_q == FRAME_LEN_C);

endmodule

// File: tb/tb_stft_frame_reader.sv
// Self-checking bench for stft_frame_reader: a RAM model plus a frame scoreboard that
// derives every expected sample from the absolute write history (frame k = hist[k*HOP +: FL]).
module tb_stft_frame_reader;

  localparam int W     = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int FL    = 16;
  localparam int HOP   = 8;

  logic          clk;
  logic          reset;
  logic          wr_strobe;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          overrun;

  logic [W-1:0]  wdata;
  logic [W-1:0]  ram [DEPTH];
  logic [AW-1:0] wptr;
  logic [W-1:0]  hist [$];
  logic [W-1:0]  vals [FL];

  int   errors;
  int   checks;
  int   mon_frame;
  int   mon_pos;
  int   mon_k;
  int   frames_seen;
  bit   mon_en;
  bit   prev_stall;
  logic [W-1:0] prev_data;

  stft_frame_reader #(
    .WORD_WIDTH(W), .ADDRESS_WIDTH(AW), .FRAME_LEN(FL), .HOP(HOP)
  ) dut (
    .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  assign rd_data = ram[rd_addr];

  // Writer side of the RAM; hist keeps every committed sample by absolute index.
  always @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      hist.delete();
    end else if (wr_strobe) begin
      ram[wptr] <= wdata;
      wptr      <= wptr + 5'd1;
      hist.push_back(wdata);
    end
  end

  // Scoreboard: checks the stream, stall stability, m_last and read address.
  always @(negedge clk) begin
    if (reset) begin
      mon_frame   = 0;
      mon_pos     = 0;
      frames_seen = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid) begin
        if (mon_en) begin
          mon_k = mon_frame * HOP + mon_pos;
          if (mon_k < hist.size()) check("frame_data", m_data, hist[mon_k]);
          else check("frame_data_written", mon_k, hist.size());
          check("m_last", m_last, (mon_pos == FL - 1));
          check("rd_addr", rd_addr, (mon_frame * HOP + mon_pos + 1) % DEPTH);
        end
        if (m_ready) begin
          mon_pos++;
          if (mon_pos == FL) begin
            mon_pos = 0;
            mon_frame++;
            frames_seen++;
          end
        end
      end else begin
        check("m_last_idle", m_last, 0);
      end
      prev_stall = m_valid & !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    int n_wr;
    errors = 0;
    checks = 0;
    mon_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    reset = 1'b1; wr_strobe = 1'b0; m_ready = 1'b0; wdata = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_m_last", m_last, 0);
    check("rst_rd_addr", rd_addr, 0);

    // 1) fifteen writes keep m_valid low; the sixteenth starts the frame a cycle later
    for (int i = 0; i < FL; i++) begin
      wr_strobe = 1'b1; wdata = W'(i);
      step();
      check("t1_no_valid", m_valid, 0);
    end
    wr_strobe = 1'b0;
    check("t1_idle_addr", rd_addr, 0);
    step();
    check("t1_valid", m_valid, 1);
    check("t1_data0", m_data, 0);

    // 2) RAM[i]=i: frame 0 = 0..15, one bubble, frame 1 = 8..23
    m_ready = 1'b1;
    for (int k = 0; k < FL; k++) begin
      wr_strobe = (k < HOP); wdata = W'(FL + k);
      step();
    end
    wr_strobe = 1'b0;
    check("t2_bubble", m_valid, 0);
    check("t2_base8", rd_addr, 8);
    step();
    check("t2_f1_valid", m_valid, 1);
    check("t2_f1_data", m_data, 8);
    repeat (FL) step();
    check("t2_f1_done", m_valid, 0);
    check("t2_base16", rd_addr, 16);
    check("t2_frames", frames_seen, 2);

    // 3) random back-pressure
    n_wr = HOP;
    for (int cyc = 0; cyc < 400 && frames_seen < 3; cyc++) begin
      m_ready = 1'($urandom_range(0, 1));
      wr_strobe = (n_wr > 0);
      wdata = W'($urandom);
      if (n_wr > 0) n_wr--;
      step();
    end
    wr_strobe = 1'b0; m_ready = 1'b1;
    check("t3_frames", frames_seen, 3);

    // 4) wrap: 40 writes interleaved with continuous reading
    for (int i = 0; i < 80; i++) begin
      wr_strobe = (i % 2 == 0); wdata = W'($urandom);
      step();
    end
    wr_strobe = 1'b0;
    repeat (120) step();
    check("t4_frames", frames_seen, 8);
    check("t4_overrun", overrun, 0);
    check("t4_idle", m_valid, 0);
    check("t4_base_wrap", rd_addr, 0);

    // 5) overrun with m_ready low; avail must saturate at DEPTH
    reset = 1'b1; m_ready = 1'b0;
    step();
    reset = 1'b0; mon_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_strobe = 1'b1; wdata = W'($urandom);
      step();
    end
    check("t5_no_overrun", overrun, 0);
    check("t5_stalled", m_valid, 1);
    step();
    check("t5_overrun", overrun, 1);
    repeat (7) step();
    wr_strobe = 1'b0;
    check("t5_sticky", overrun, 1);
    m_ready = 1'b1;
    repeat (100) step();
    check("t5_sat_frames", frames_seen, 3);
    check("t5_sticky_end", overrun, 1);

    // 6) reset mid-frame at sample 5
    reset = 1'b1;
    step();
    reset = 1'b0; mon_en = 1'b1;
    for (int i = 0; i < FL; i++) begin
      wdata = W'($urandom); vals[i] = wdata; wr_strobe = 1'b1;
      step();
    end
    wr_strobe = 1'b0;
    step();
    check("t6_start", m_data, vals[0]);
    repeat (5) step();
    check("t6_sample5", m_data, vals[5]);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_last", m_last, 0);
    check("t6_rst_data", m_data, 0);
    check("t6_rst_addr", rd_addr, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < FL; i++) begin
      wdata = W'($urandom); vals[i] = wdata; wr_strobe = 1'b1;
      step();
    end
    wr_strobe = 1'b0;
    check("t6_idle_addr", rd_addr, 0);
    check("t6_idle_valid", m_valid, 0);
    step();
    check("t6_new_valid", m_valid, 1);
    check("t6_new_data", m_data, vals[0]);
    repeat (20) step();
    check("t6_frames", frames_seen, 1);
    check("t6_done", m_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
